// File: rtl/gradient_engine.sv
// Central-difference x/y gradient engine with edge replication over a runtime-sized image in BRAM.
// Optional |gx|+|gy| magnitude output is enabled with `define GRADIENT_MAG_EN.
module gradient_engine #(
  parameter int MAX_WIDTH    = 64,
  parameter int MAX_HEIGHT   = 64,
  parameter int BIT_DEPTH    = 8,
  parameter int ADDR_WIDTH   = 13,
  parameter int READ_LATENCY = 2,
  parameter int HALF_SCALE   = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic [$clog2(MAX_WIDTH):0]    img_width_in,
  input  logic [$clog2(MAX_HEIGHT):0]   img_height_in,
  input  logic [ADDR_WIDTH-1:0]         read_base_in,
  input  logic [ADDR_WIDTH-1:0]         write_base_in,
  output logic [ADDR_WIDTH-1:0]         ext_read_addr,
  output logic                          ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]          ext_pixel_in,
  output logic [ADDR_WIDTH-1:0]         x_write_addr,
  output logic                          x_write_valid,
  output logic [BIT_DEPTH:0]            x_pixel_out,
  output logic [ADDR_WIDTH-1:0]         y_write_addr,
  output logic                          y_write_valid,
  output logic [BIT_DEPTH:0]            y_pixel_out,
  output logic                          busy_out,
  output logic                          gradient_done
`ifdef GRADIENT_MAG_EN
  ,
  output logic [BIT_DEPTH:0]            mag_pixel_out
`endif
);

  // state | meaning
  // IDLE  | waiting for start_in; zero-size frames finish here
  // ISSUE | four reads: left, right, up, down neighbour
  // WAIT  | READ_LATENCY cycles for the last return
  // WRITE | gx/gy written, raster position advances
  localparam int WW = $clog2(MAX_WIDTH) + 1;
  localparam int HW = $clog2(MAX_HEIGHT) + 1;
  localparam int AW = ADDR_WIDTH;
  localparam int RL = READ_LATENCY;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_WRITE = 4'b1000
  } state_t;

  state_t state, state_nxt;

  logic [WW-1:0]        w_q, x_q, x_last, w_clamp, col_l, col_r;
  logic [HW-1:0]        h_q, y_q, y_last, h_clamp;
  logic [AW-1:0]        rbase_q, wbase_q, row_off_q, w_ext, off_u, off_d, rd_addr;
  logic [1:0]           idx_q;
  logic [2:0]           wait_cnt_q;
  logic [RL-1:0]        tag_v;
  logic [1:0]           tag_i [RL];
  logic [BIT_DEPTH-1:0] pix_l, pix_r, pix_u, pix_d;
  logic                 done_q, zero_sz, last_px;
  logic signed [BIT_DEPTH:0] op_l, op_r, op_u, op_d, dx, dy, gx_v, gy_v;

  assign w_clamp = (img_width_in > WW'(MAX_WIDTH)) ? WW'(MAX_WIDTH) : img_width_in;
  assign h_clamp = (img_height_in > HW'(MAX_HEIGHT)) ? HW'(MAX_HEIGHT) : img_height_in;
  assign zero_sz = (w_clamp == '0) || (h_clamp == '0);
  assign x_last  = w_q - WW'(1);
  assign y_last  = h_q - HW'(1);
  assign last_px = (x_q == x_last) && (y_q == y_last);
  assign w_ext   = AW'(w_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_in && !zero_sz) state_nxt = S_ISSUE;
      S_ISSUE: if (idx_q == 2'd3) state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt_q == 3'd0) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_px ? S_IDLE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ext_read_addr_valid = 1'b0;
    x_write_valid       = 1'b0;
    y_write_valid       = 1'b0;
    busy_out            = (state != S_IDLE);
    case (state)
      S_ISSUE: ext_read_addr_valid = 1'b1;
      S_WRITE: begin
        x_write_valid = 1'b1;
        y_write_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      w_q        <= '0;
      h_q        <= '0;
      rbase_q    <= '0;
      wbase_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_off_q  <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == S_IDLE && start_in && zero_sz) || (state == S_WRITE && last_px);
      case (state)
        S_IDLE: if (start_in) begin
          w_q       <= w_clamp;
          h_q       <= h_clamp;
          rbase_q   <= read_base_in;
          wbase_q   <= write_base_in;
          x_q       <= '0;
          y_q       <= '0;
          row_off_q <= '0;
          idx_q     <= '0;
        end
        S_ISSUE: begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) wait_cnt_q <= 3'(RL - 1);
        end
        S_WAIT: if (wait_cnt_q != 3'd0) wait_cnt_q <= wait_cnt_q - 3'd1;
        S_WRITE: begin
          if (x_q == x_last) begin
            x_q       <= '0;
            y_q       <= y_q + HW'(1);
            row_off_q <= row_off_q + w_ext;
          end else begin
            x_q <= x_q + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Each read carries its neighbour index down a tag pipe matching the BRAM latency.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_v <= '0;
      for (int i = 0; i < RL; i++) tag_i[i] <= '0;
      pix_l <= '0;
      pix_r <= '0;
      pix_u <= '0;
      pix_d <= '0;
    end else begin
      tag_v[0] <= (state == S_ISSUE);
      tag_i[0] <= idx_q;
      for (int i = 1; i < RL; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_i[i] <= tag_i[i-1];
      end
      if (tag_v[RL-1]) begin
        case (tag_i[RL-1])
          2'd0: pix_l <= ext_pixel_in;
          2'd1: pix_r <= ext_pixel_in;
          2'd2: pix_u <= ext_pixel_in;
          default: pix_d <= ext_pixel_in;
        endcase
      end
    end
  end

  always_comb begin
    col_l = (x_q == '0) ? x_q : x_q - WW'(1);
    col_r = (x_q == x_last) ? x_q : x_q + WW'(1);
    off_u = (y_q == '0) ? row_off_q : row_off_q - w_ext;
    off_d = (y_q == y_last) ? row_off_q : row_off_q + w_ext;
    case (idx_q)
      2'd0:    rd_addr = rbase_q + row_off_q + AW'(col_l);
      2'd1:    rd_addr = rbase_q + row_off_q + AW'(col_r);
      2'd2:    rd_addr = rbase_q + off_u + AW'(x_q);
      default: rd_addr = rbase_q + off_d + AW'(x_q);
    endcase
    ext_read_addr = (state == S_ISSUE) ? rd_addr : '0;
    x_write_addr  = (state == S_WRITE) ? wbase_q + row_off_q + AW'(x_q) : '0;
    y_write_addr  = x_write_addr;
  end

  always_comb begin
    op_l = $signed({1'b0, pix_l});
    op_r = $signed({1'b0, pix_r});
    op_u = $signed({1'b0, pix_u});
    op_d = $signed({1'b0, pix_d});
    dx   = op_r - op_l;
    dy   = op_d - op_u;
    gx_v = (HALF_SCALE != 0) ? (dx >>> 1) : dx;
    gy_v = (HALF_SCALE != 0) ? (dy >>> 1) : dy;
    x_pixel_out = (state == S_WRITE) ? gx_v : '0;
    y_pixel_out = (state == S_WRITE) ? gy_v : '0;
  end

  assign gradient_done = done_q;

`ifdef GRADIENT_MAG_EN
  logic signed [BIT_DEPTH+1:0] gx_w, gy_w;
  logic [BIT_DEPTH+1:0]        abs_x, abs_y, mag_sum;

  always_comb begin
    gx_w    = {gx_v[BIT_DEPTH], gx_v};
    gy_w    = {gy_v[BIT_DEPTH], gy_v};
    abs_x   = gx_w[BIT_DEPTH+1] ? -gx_w : gx_w;
    abs_y   = gy_w[BIT_DEPTH+1] ? -gy_w : gy_w;
    mag_sum = abs_x + abs_y;
    if (state != S_WRITE)         mag_pixel_out = '0;
    else if (mag_sum[BIT_DEPTH+1]) mag_pixel_out = '1;
    else                          mag_pixel_out = mag_sum[BIT_DEPTH:0];
  end
`endif

endmodule

// File: tb/tb_gradient_engine.sv
// Directed bench for gradient_engine: three instances (RL=2/half, RL=2/full, RL=4/half) share one image memory.
module tb_gradient_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  img_w = '0, img_h = '0;
  logic [12:0] rbase = '0, wbase = '0;
  logic [2:0]  start = '0;
  logic [2:0]  rd_v, xv, yv, busy, done;
  logic [12:0] rd_addr [3];
  logic [12:0] xa [3];
  logic [12:0] ya [3];
  logic [7:0]  pix [3];
  logic [8:0]  xp [3];
  logic [8:0]  yp [3];
`ifdef GRADIENT_MAG_EN
  logic [8:0]  mag [3];
`endif
  logic [7:0]  img [0:8191];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 2) ? 4 : 2;
    localparam int HS = (g == 1) ? 0 : 1;
    logic [7:0] dpipe [4];
    logic signed [8:0] gx_o [0:8191];
    logic signed [8:0] gy_o [0:8191];
    logic [8:0] mag_o [0:8191];
    int n_rd = 0, n_wr = 0, n_done = 0, rd_sum = 0;

    gradient_engine #(
      .MAX_WIDTH(64), .MAX_HEIGHT(64), .BIT_DEPTH(8), .ADDR_WIDTH(13),
      .READ_LATENCY(RL), .HALF_SCALE(HS)
    ) u_dut (
`ifdef GRADIENT_MAG_EN
      .mag_pixel_out(mag[g]),
`endif
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start[g]),
      .img_width_in(img_w), .img_height_in(img_h),
      .read_base_in(rbase), .write_base_in(wbase),
      .ext_read_addr(rd_addr[g]), .ext_read_addr_valid(rd_v[g]), .ext_pixel_in(pix[g]),
      .x_write_addr(xa[g]), .x_write_valid(xv[g]), .x_pixel_out(xp[g]),
      .y_write_addr(ya[g]), .y_write_valid(yv[g]), .y_pixel_out(yp[g]),
      .busy_out(busy[g]), .gradient_done(done[g])
    );

    always @(posedge clk) begin
      dpipe[0] <= img[rd_addr[g]];
      for (int i = 1; i < 4; i++) dpipe[i] <= dpipe[i-1];
    end
    assign pix[g] = dpipe[RL-1];

    always @(posedge clk) begin
      if (rd_v[g]) begin
        n_rd   <= n_rd + 1;
        rd_sum <= rd_sum + int'(rd_addr[g]);
      end
      if (xv[g]) begin
        n_wr <= n_wr + 1;
        gx_o[xa[g]] <= xp[g];
`ifdef GRADIENT_MAG_EN
        mag_o[xa[g]] <= mag[g];
`endif
      end
      if (yv[g]) gy_o[ya[g]] <= yp[g];
      if (done[g]) n_done <= n_done + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Start a frame on instance g, scramble the size/base inputs while busy, and count cycles to done.
  task automatic run_frame(input int g, input int w, input int h, input int rb, input int wb,
                           input int poke, output int cyc);
    @(negedge clk);
    img_w = 7'(w); img_h = 7'(h); rbase = 13'(rb); wbase = 13'(wb);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    img_w = 7'd0; img_h = 7'd0; rbase = 13'h1fff; wbase = 13'h1fff;
    cyc = 1;
    while (!done[g] && cyc < 40000) begin
      if (cyc == poke) begin
        start[g] = 1'b1;
        check("busy_mid_frame", int'(busy[g]), 1);
      end else begin
        start[g] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start[g] = 1'b0;
    check("done_seen", int'(done[g]), 1);
  endtask

  function automatic int px(input int rb, input int w, input int h, input int x, input int y);
    int cx, cy;
    cx = (x < 0) ? 0 : ((x > w - 1) ? w - 1 : x);
    cy = (y < 0) ? 0 : ((y > h - 1) ? h - 1 : y);
    return int'(img[rb + cy * w + cx]);
  endfunction

  int cyc, b_rd, b_wr, b_done, b_sum;
  int ramp_exp [4] = '{5, 10, 10, 5};
  int col_exp [3] = '{25, 50, 25};

  initial begin
    for (int i = 0; i < 8192; i++) img[i] = 8'd0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) img[y*4 + x] = 8'(10 * x);
    img[100] = 8'd0; img[101] = 8'd50; img[102] = 8'd100;
    img[505] = 8'd255;
    img[601] = 8'd255; img[605] = 8'd255;
    for (int i = 0; i < 64; i++) img[1000 + i] = 8'($urandom_range(0, 255));

    repeat (3) @(negedge clk);
    check("rst_rd_valid", int'(rd_v[0]), 0);
    check("rst_rd_addr", int'(rd_addr[0]), 0);
    check("rst_wr_valid", int'(xv[0]), 0);
    check("rst_xpix", int'(xp[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_done", int'(done[0]), 0);
    rst_n = 1'b1;

    // 4x4 ramp
    b_rd = g_dut[0].n_rd; b_wr = g_dut[0].n_wr;
    run_frame(0, 4, 4, 0, 1000, -1, cyc);
    check("ramp_cycles", cyc, 113);
    check("ramp_reads", g_dut[0].n_rd - b_rd, 64);
    check("ramp_writes", g_dut[0].n_wr - b_wr, 16);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        check("ramp_gx", int'(g_dut[0].gx_o[1000 + y*4 + x]), ramp_exp[x]);
        check("ramp_gy", int'(g_dut[0].gy_o[1000 + y*4 + x]), 0);
      end
    @(negedge clk);
    check("done_one_cycle", int'(done[0]), 0);

    // single column, offset bases
    b_rd = g_dut[0].n_rd; b_sum = g_dut[0].rd_sum;
    run_frame(0, 1, 3, 100, 200, -1, cyc);
    check("col_cycles", cyc, 22);
    check("col_reads", g_dut[0].n_rd - b_rd, 12);
    check("col_addr_sum", g_dut[0].rd_sum - b_sum, 1212);
    for (int y = 0; y < 3; y++) begin
      check("col_gx", int'(g_dut[0].gx_o[200 + y]), 0);
      check("col_gy", int'(g_dut[0].gy_o[200 + y]), col_exp[y]);
    end

    // height clamp 127 -> 64
    run_frame(0, 1, 127, 300, 3000, -1, cyc);
    check("clamp_cycles", cyc, 449);

    // zero width
    b_rd = g_dut[0].n_rd; b_wr = g_dut[0].n_wr;
    run_frame(0, 0, 4, 0, 7000, -1, cyc);
    check("w0_cycles", cyc, 1);
    @(negedge clk);
    check("w0_busy", int'(busy[0]), 0);
    check("w0_reads", g_dut[0].n_rd - b_rd, 0);
    check("w0_writes", g_dut[0].n_wr - b_wr, 0);

    // start pulsed mid-frame
    b_done = g_dut[0].n_done;
    run_frame(0, 4, 4, 0, 1100, 30, cyc);
    check("restart_cycles", cyc, 113);
    repeat (3) @(negedge clk);
    check("restart_done_count", g_dut[0].n_done - b_done, 1);
    check("restart_gx", int'(g_dut[0].gx_o[1100 + 9]), 10);

    // reset mid-frame
    b_done = g_dut[0].n_done;
    @(negedge clk);
    img_w = 7'd4; img_h = 7'd4; rbase = 13'd0; wbase = 13'd1300;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_rd_valid", int'(rd_v[0]), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rd_valid", int'(rd_v[0]), 0);
    check("async_rst_rd_addr", int'(rd_addr[0]), 0);
    check("async_rst_busy", int'(busy[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("abort_no_done", g_dut[0].n_done - b_done, 0);
    run_frame(0, 4, 4, 0, 1200, -1, cyc);
    check("after_rst_cycles", cyc, 113);
    check("after_rst_gx", int'(g_dut[0].gx_o[1200 + 11]), 5);

    // single bright pixel, full-scale differences
    run_frame(1, 4, 4, 500, 4000, -1, cyc);
    check("spike_gx_0_1", int'(g_dut[1].gx_o[4004]), 255);
    check("spike_gx_2_1", int'(g_dut[1].gx_o[4006]), -255);
    check("spike_gx_1_1", int'(g_dut[1].gx_o[4005]), 0);
    check("spike_gy_1_0", int'(g_dut[1].gy_o[4001]), 255);
    check("spike_gy_1_2", int'(g_dut[1].gy_o[4009]), -255);
    check("spike_corner", int'(g_dut[1].gx_o[4000]), 0);

    // opposite-sign extremes at the centre of a 3x3
    run_frame(1, 3, 3, 600, 5000, -1, cyc);
    check("ext_gx", int'(g_dut[1].gx_o[5004]), 255);
    check("ext_gy", int'(g_dut[1].gy_o[5004]), -255);
`ifdef GRADIENT_MAG_EN
    check("ext_mag", int'(g_dut[1].mag_o[5004]), 510);
    check("ext_mag_corner", int'(g_dut[1].mag_o[5000]), 255);
`endif

    // random 8x8 at read latency 4
    run_frame(2, 8, 8, 1000, 6000, -1, cyc);
    check("rl4_cycles", cyc, 577);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        check("rl4_gx", int'(g_dut[2].gx_o[6000 + y*8 + x]),
              (px(1000, 8, 8, x + 1, y) - px(1000, 8, 8, x - 1, y)) >>> 1);
        check("rl4_gy", int'(g_dut[2].gy_o[6000 + y*8 + x]),
              (px(1000, 8, 8, x, y + 1) - px(1000, 8, 8, x, y - 1)) >>> 1);
      end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
